// File: rtl/bus_seq_pkg.sv
// rtl/bus_seq_pkg.sv - shared state encoding and rw constants for the phi2 bus sequencer
package bus_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_HOLD = 3'd2,
    WR_WAIT = 3'd3,
    WR_REQ  = 3'd4
  } bus_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/phi2_bus_sequencer_if.sv
// rtl/phi2_bus_sequencer_if.sv - synchronous req/ack memory port between sequencer and memory
interface phi2_bus_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/req_timeout_counter.sv
// rtl/req_timeout_counter.sv - saturating wait counter flagging a stalled req/ack port
module req_timeout_counter #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 15
) (
  input  logic sys_clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic hit
);
  localparam logic [CNT_W-1:0] HIT_AT  = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count;

  // hit fires in the LIMIT-th waiting cycle so the owner drops req on that edge
  assign hit = enable && (count == HIT_AT);

  // count waiting cycles, cleared while no request is outstanding
  always_ff @(posedge sys_clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/phi2_bus_sequencer.sv
// rtl/phi2_bus_sequencer.sv - sequences one CPU bus cycle per phi2 period onto the memory port
module phi2_bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  phi2_rise,
  input  logic                  phi2_fall,
  input  logic                  cpu_rw,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  rdata_valid,
  phi2_bus_sequencer_if.master  mem,
  input  logic                  err_clear,
  output logic                  late_err,
  output logic                  overlap_err,
  output logic                  timeout_err,
  output logic                  busy
);
  bus_state_e state;
  logic       late_q;
  logic       tmo_hit;
  logic       rise_ok;
  logic       fall_ok;

  // simultaneous edges are illegal, so neither is acted on
  assign rise_ok = phi2_rise & ~phi2_fall;
  assign fall_ok = phi2_fall & ~phi2_rise;
  assign busy    = (state != IDLE);

  req_timeout_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .sys_clock (sys_clock),
    .reset     (reset),
    .clear     (~mem.mem_req),
    .enable    (mem.mem_req & ~mem.mem_ack),
    .hit       (tmo_hit)
  );

  // bus cycle FSM; error clears come first so a same-cycle error set overrides them
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state         <= IDLE;
      late_q        <= 1'b0;
      cpu_rdata     <= '0;
      rdata_valid   <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      late_err      <= 1'b0;
      overlap_err   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      if (err_clear) begin
        late_err    <= 1'b0;
        overlap_err <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (phi2_rise && (phi2_fall || (state != IDLE))) begin
        overlap_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (rise_ok) begin
            mem.mem_addr <= cpu_addr;
            if (cpu_rw == RW_READ) begin
              mem.mem_req <= 1'b1;
              mem.mem_we  <= 1'b0;
              state       <= RD_REQ;
            end else begin
              state       <= WR_WAIT;
            end
          end
        end
        RD_REQ: begin
          if (mem.mem_ack) begin
            cpu_rdata   <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            late_q      <= 1'b0;
            // data arriving on or after phi2_fall is too late for the CPU to use
            if (late_q || fall_ok) begin
              state       <= IDLE;
            end else begin
              rdata_valid <= 1'b1;
              state       <= RD_HOLD;
            end
          end else if (tmo_hit) begin
            mem.mem_req <= 1'b0;
            timeout_err <= 1'b1;
            late_q      <= 1'b0;
            state       <= IDLE;
          end else if (fall_ok && !late_q) begin
            late_q   <= 1'b1;
            late_err <= 1'b1;
          end
        end
        RD_HOLD: begin
          if (fall_ok) begin
            rdata_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        WR_WAIT: begin
          if (fall_ok) begin
            mem.mem_wdata <= cpu_wdata;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            state         <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= IDLE;
          end else if (tmo_hit) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/phi2_bus_sequencer.md
Name: phi2_bus_sequencer

Overview:
Controller that sequences one 6502-style bus cycle per phi2 period, driven by the single-cycle phi2 rising/falling edge pulses from the async edge-detect stage.
Converts each CPU read or write into one req/ack transaction on the synchronous memory port, running on sys_clock.
Detects protocol faults: late memory, overlapping cycles and a stalled memory port.
Sits between the edge-detect stage and the on-chip RAM/ROM/IO decode.

Parameters:
ADDR_W, 16, CPU and memory address width
DATA_W, 8, data width
TIMEOUT, 15, max sys_clock cycles mem_req may stay high without mem_ack before abort
CNT_W, 4, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
sys_clock  in  1  system clock
reset  in  1  synchronous, active-high reset
phi2_rise  in  1  one-cycle pulse, phi2 rising edge
phi2_fall  in  1  one-cycle pulse, phi2 falling edge
cpu_rw  in  1  1=read, 0=write; sampled on phi2_rise
cpu_addr  in  ADDR_W  sampled on phi2_rise
cpu_wdata  in  DATA_W  sampled on phi2_fall (write cycles)
cpu_rdata  out  DATA_W  read data returned to CPU
rdata_valid  out  1  cpu_rdata valid for current read
mem_req  out  1  memory request; held until mem_ack or abort
mem_we  out  1  write strobe qualifier for mem_req
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_ack  in  1  one-cycle completion; mem_rdata valid same cycle
mem_rdata  in  DATA_W  memory read data
err_clear  in  1  clears all sticky error flags
late_err  out  1  sticky: read not complete by phi2_fall
overlap_err  out  1  sticky: phi2_rise while busy
timeout_err  out  1  sticky: mem_ack missing for TIMEOUT cycles
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0, including cpu_rdata, mem_addr and mem_wdata; counter 0.
- States: IDLE, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ. All outputs are registered.
- IDLE:
  - On phi2_rise, latch cpu_addr into mem_addr and latch cpu_rw.
  - Read goes to RD_REQ; write goes to WR_WAIT.
  - mem_req rises in the cycle after the phi2_rise pulse (1-cycle latency).
- RD_REQ (mem_req=1, mem_we=0):
  - On mem_ack: cpu_rdata<=mem_rdata, rdata_valid<=1, mem_req<=0, go to RD_HOLD.
  - If phi2_fall arrives first: set late_err and stay in RD_REQ until ack or timeout.
  - On completion after a late phi2_fall: return to IDLE with rdata_valid staying 0; cpu_rdata is still updated.
- RD_HOLD: on phi2_fall, rdata_valid<=0 and go to IDLE. cpu_rdata holds its value until the next read ack.
- WR_WAIT: on phi2_fall, mem_wdata<=cpu_wdata and go to WR_REQ. mem_req rises the following cycle.
- WR_REQ (mem_req=1, mem_we=1): on mem_ack, mem_req<=0 and mem_we<=0, go to IDLE.
- Timeout:
  - The counter clears whenever mem_req=0 and increments each cycle mem_req=1 without ack.
  - When the count reaches TIMEOUT: drop mem_req and mem_we, set timeout_err, go to IDLE.
  - mem_ack in the same cycle as the limit wins; no error.
- phi2_rise in any non-IDLE state: set overlap_err and ignore the cycle. The current transaction continues unaffected.
- phi2_rise and phi2_fall together (illegal from the edge stage): both are ignored and overlap_err is set.
- phi2_fall in IDLE: ignored.
- mem_ack with mem_req=0: ignored.
- Error flags:
  - Sticky until err_clear.
  - If err_clear and a new error occur in the same cycle, set wins.
- Reset mid-transaction: immediate return to IDLE and mem_req=0 the next edge. Memory must tolerate request withdrawal.

Decomposition:
- Shared package bus_seq_pkg holds:
  - state encoding enum (IDLE=0, RD_REQ, RD_HOLD, WR_WAIT, WR_REQ);
  - RW_READ=1 / RW_WRITE=0 constants.
- One sub-module, req_timeout_counter: saturating counter with clear/enable and a hit output, reusable for other req/ack ports.

Test Plan:
- Read, 2-cycle ack: rise with rw=1, addr=0xFFFC; ack 2 cycles after mem_req with rdata=0x5A -> mem_req high 1 cycle after rise, rdata_valid=1 with cpu_rdata=0x5A until phi2_fall, then busy=0.
- Write: rise with rw=0, addr=0x0200; fall with wdata=0xA5; ack 1 cycle later -> mem_we=1 and mem_wdata=0xA5 only after fall, no errors.
- Late read: ack arrives 3 cycles after phi2_fall -> late_err=1, rdata_valid never asserted, IDLE after ack.
- Timeout: no ack with TIMEOUT=15 -> mem_req drops after exactly 15 request cycles, timeout_err=1; err_clear drives it to 0.
- Overlap: second phi2_rise during RD_REQ -> overlap_err=1, mem_addr unchanged, first read completes normally.
- Reset mid-write in WR_REQ -> next cycle mem_req=0, busy=0, all flags 0; a following normal read succeeds.
